mmu_loader: RTL and testbench
=============================

# mmu_loader

Hardware sequencer that bulk-loads the MMU translation table from a table held in memory. It is the initiator side of the MMU register interface. It reads one descriptor word per entry over a simple request/acknowledge memory port, then issues the select-write and entry-write pair to the MMU for that entry. At the end it restores the MMU fault register to its pre-load value, so an in-progress fault handler's state survives a context-switch reload.

## Interface

Parameters:
- RV, 16: data word width.
- PA, RV: physical address width.
- VA, RV: virtual address width; must equal RV.
- NMMU, 8: pages per bank; power of two. There are 4 banks (ins, sup), so the table holds 4*NMMU entries.

Ports:
- clk, input, 1: clock.
- reset_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin a load. Sampled only while idle; ignored while busy.
- base_addr, input, PA-RV/16: word address of table entry 0. Sampled with start.
- bank_mask, input, 4: bit b enables bank b = {ins, sup}. Sampled with start.
- busy, output, 1: load in progress.
- done, output, 1: one-cycle pulse when a load completes.
- mem_req, output, 1: read request.
- mem_addr, output, PA-RV/16: read word address.
- mem_ack, input, 1: read data valid this cycle; completes the request.
- mem_rdata, input, RV: read data.
- reg_write, output, 1: MMU register write strobe.
- reg_data, output, RV: MMU register write data.
- reg_read, input, RV: MMU fault register readback.
- mmu_fault, input, 1: MMU fault capture. A reg_write in the same cycle is discarded by the MMU.

## Operation

- Entry index i runs over the range 0 to 4*NMMU-1, with i = {ins, sup, page}. The bank is i[log2(NMMU)+1 : log2(NMMU)]. Entries of masked banks are skipped; they cause no read and no write.
- Table word i lives at base_addr + i, modulo 2^(PA-RV/16). Addresses wrap and are never saturated.
- The descriptor format matches the MMU entry write: bits [RV-1:RV-(PA-VA+log2(NMMU))] hold the physical page, bit 2 is writeable, bit 1 is valid. Bit 0 is ignored and forced to 1 on write.
- States:
  - IDLE: start with bank_mask != 0 goes to SAVE. start with bank_mask == 0 pulses done the next cycle, with no busy and no writes.
  - SAVE: captures reg_read into the saved register. Sets i to the first enabled entry. Goes to READ.
  - READ: mem_req=1 and mem_addr=base+i are held stable until mem_ack. On mem_ack, mem_rdata is captured, mem_req drops, and the state goes to SEL.
  - SEL: reg_write=1. reg_data carries page in [RV-1:RV-log2(NMMU)], ins in bit 3, sup in bit 2, and zeros elsewhere (bit 0 = 0). Goes to ENT.
  - ENT: reg_write=1 and reg_data = {captured[RV-1:1], 1'b1}. Then i advances to the next enabled entry. If one exists the state goes to READ; otherwise it goes to RESTORE.
  - RESTORE: reg_write=1 and reg_data = {saved[RV-1:1], 1'b0}. Goes to DONE.
  - DONE: done=1 and busy=0 for one cycle. Goes to IDLE.
- mmu_fault stall rule: a write state advances only on an edge where mmu_fault=0. While mmu_fault=1, reg_write and reg_data hold unchanged. This causes no duplicate and no skipped write.
- busy=1 in every state except IDLE and DONE.

## Timing

- All outputs are registered.
- Reset values: busy=0, done=0, mem_req=0, mem_addr=0, reg_write=0, reg_data=0, state=IDLE.
- reset_n low mid-load:
  - Outputs clear immediately and the sequencer returns to IDLE.
  - No restore write is issued. MMU contents are partial; software restarts the load.
- Latency with zero-wait memory and no mmu_fault stalls:
  - SAVE: 1 cycle.
  - Each enabled entry: 3 cycles (READ with ack in its first cycle, SEL, ENT).
  - RESTORE: 1 cycle.
  - DONE: 1 cycle.
- Full load (NMMU=8, 32 entries): busy is high for 98 cycles. done pulses in the 99th cycle after the start edge.
- Each memory wait cycle adds 1 cycle. Each cycle of mmu_fault=1 during a write state adds 1 cycle.
- mem_ack seen while mem_req=0 is ignored.

## Test plan

- Full load, RV=16, NMMU=8, bank_mask=4'hF, base=0x0100, zero-wait ack, table[i]=(i<<11)|6:
  - 32 reads at 0x0100 through 0x011F.
  - Entry 5: select 0xA000, then entry 0x2807.
  - Entry 13: select 0xA004.
  - Entry 29: select 0xA00C.
  - busy high for 98 cycles, then a done pulse.
- bank_mask=4'b0100: only entries 16 to 23 are read (base+16 to base+23). There are 16 entry writes plus 1 restore, and select words have bit3=1, bit2=0. bank_mask=0: done next cycle, no mem_req, no reg_write.
- mmu_fault held high for 2 cycles during an SEL write: reg_write and reg_data are unchanged for 3 cycles. The write is counted once, and the total load time grows by 2 cycles.
- mem_ack delayed 3 cycles: mem_req and mem_addr are stable for 4 cycles, and the data from the ack cycle appears in the entry write.
- reg_read=0x6008 at start: the final write is 0x6008. base=0x7FF0 (15-bit word address) wraps so that entry 31 is read at 0x000F.
- reset_n pulsed low during entry 10: all outputs are 0 in the same cycle. A subsequent start reloads from entry 0 with the correct sequence.

Source files
------------

// File: rtl/mmu_loader.sv
//==============================================================================
// Module   : mmu_loader
// Brief    : Bulk-loads the MMU translation table from memory, one descriptor
//            per entry, then restores the MMU fault register.
// Revision : 1.0
//==============================================================================
`default_nettype none

module mmu_loader #(
  parameter int RV   = 16,
  parameter int PA   = RV,
  parameter int VA   = RV,
  parameter int NMMU = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [PA-RV/16-1:0]  base_addr,
  input  logic [3:0]           bank_mask,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_req,
  output logic [PA-RV/16-1:0]  mem_addr,
  input  logic                 mem_ack,
  input  logic [RV-1:0]        mem_rdata,
  output logic                 reg_write,
  output logic [RV-1:0]        reg_data,
  input  logic [RV-1:0]        reg_read,
  input  logic                 mmu_fault
);

  localparam int AW = PA - RV/16;
  localparam int PW = $clog2(NMMU);
  localparam int IW = PW + 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SAVE    = 3'd1,
    S_READ    = 3'd2,
    S_SEL     = 3'd3,
    S_ENT     = 3'd4,
    S_RESTORE = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   base_q;
  logic [3:0]      mask_q;
  logic [RV-2:0]   saved_q;
  logic [RV-2:0]   capt_q;

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            mem_req_q, mem_req_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic            reg_write_q, reg_write_d;
  logic [RV-1:0]   reg_data_q, reg_data_d;

  logic [IW:0]     w_inc;
  logic [IW:0]     w_first;
  logic [IW:0]     w_next;
  logic [RV-1:0]   w_sel;

  // Descriptor bit 0 and fault bit 0 are replaced on write; VA only sizes the page field.
  logic            unused_ok;
  assign unused_ok = ^{mem_rdata[0], reg_read[0], VA[0]};

  // Returns {none, index} for the first entry of the lowest enabled bank >= b0.
  function automatic logic [IW:0] first_from(input logic [2:0] b0, input logic [3:0] m);
    logic [IW:0] r;
    r = {1'b1, {IW{1'b0}}};
    for (int b = 3; b >= 0; b--) begin
      if (b >= int'(b0) && m[b]) r = {1'b0, 2'(b), {PW{1'b0}}};
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    w_inc       = {1'b0, idx_q} + (IW+1)'(1);
    w_first     = first_from(3'd0, mask_q);
    w_next      = {1'b1, {IW{1'b0}}};
    w_sel       = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    mem_req_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    reg_write_d = 1'b0;
    reg_data_d  = reg_data_q;

    if (w_inc[IW]) begin
      w_next = {1'b1, {IW{1'b0}}};
    end else if (w_inc[PW-1:0] != '0) begin
      w_next = w_inc;
    end else begin
      w_next = first_from({1'b0, w_inc[IW-1:PW]}, mask_q);
    end

    case (state_q)
      S_IDLE: begin
        if (start) state_d = (bank_mask != 4'd0) ? S_SAVE : S_DONE;
      end
      S_SAVE: begin
        idx_d   = w_first[IW-1:0];
        state_d = S_READ;
      end
      S_READ: begin
        if (mem_ack) state_d = S_SEL;
      end
      S_SEL: begin
        if (!mmu_fault) state_d = S_ENT;
      end
      S_ENT: begin
        if (!mmu_fault) begin
          if (w_next[IW]) begin
            state_d = S_RESTORE;
          end else begin
            idx_d   = w_next[IW-1:0];
            state_d = S_READ;
          end
        end
      end
      S_RESTORE: begin
        if (!mmu_fault) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    w_sel[RV-1 -: PW] = idx_d[PW-1:0];
    w_sel[3]          = idx_d[PW+1];
    w_sel[2]          = idx_d[PW];

    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    mem_req_d   = (state_d == S_READ);
    reg_write_d = (state_d == S_SEL) || (state_d == S_ENT) || (state_d == S_RESTORE);
    if (state_d == S_READ) mem_addr_d = base_q + AW'(idx_d);

    case (state_d)
      S_SEL:     reg_data_d = w_sel;
      S_ENT:     reg_data_d = {capt_q, 1'b1};
      S_RESTORE: reg_data_d = {saved_q, 1'b0};
      default:   reg_data_d = reg_data_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      base_q      <= '0;
      mask_q      <= '0;
      saved_q     <= '0;
      capt_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      reg_write_q <= 1'b0;
      reg_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      reg_write_q <= reg_write_d;
      reg_data_q  <= reg_data_d;
      if (state_q == S_IDLE && start) begin
        base_q <= base_addr;
        mask_q <= bank_mask;
      end
      if (state_q == S_SAVE) saved_q <= reg_read[RV-1:1];
      if (state_q == S_READ && mem_ack) capt_q <= mem_rdata[RV-1:1];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign reg_write = reg_write_q;
  assign reg_data  = reg_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mmu_loader.sv
//==============================================================================
// Module   : tb_mmu_loader
// Brief    : Directed scoreboard bench for mmu_loader (RV=16, NMMU=8).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_mmu_loader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [14:0] base_addr;
  logic [3:0]  bank_mask;
  logic        busy;
  logic        done;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        reg_write;
  logic [15:0] reg_data;
  logic [15:0] reg_read;
  logic        mmu_fault;

  mmu_loader #(.RV(16), .NMMU(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .bank_mask (bank_mask),
    .busy      (busy),
    .done      (done),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .reg_write (reg_write),
    .reg_data  (reg_data),
    .reg_read  (reg_read),
    .mmu_fault (mmu_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_w[$];
  logic [14:0] exp_a[$];
  int          ack_delay = 0;
  int          fault_at = -1;
  int          fault_left = 0;
  int          wr_idx = 0;
  int          rd_cnt = 0;
  int          busy_cnt = 0;
  int          done_cnt = 0;
  logic [14:0] tb_base = 15'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Table word i = (i<<11)|6, where i is the offset from the current base.
  function automatic logic [15:0] tbl_word(input logic [14:0] a);
    logic [14:0] i;
    i = a - tb_base;
    return {i[4:0], 11'd0} | 16'h0006;
  endfunction

  // Memory responder: acks after ack_delay wait cycles, scrambles data otherwise.
  initial begin
    int          req_cycles;
    logic [14:0] req_addr;
    req_cycles = 0;
    req_addr   = '0;
    mem_ack    = 1'b0;
    mem_rdata  = 16'hDEAD;
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 16'hDEAD;
      if (reset_n === 1'b1 && mem_req === 1'b1) begin
        if (req_cycles == 0) req_addr = mem_addr;
        else chk("rd_addr_stable", mem_addr, req_addr);
        req_cycles++;
        if (req_cycles > ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = tbl_word(mem_addr);
          rd_cnt++;
          if (exp_a.size() > 0) chk("rd_addr", mem_addr, exp_a.pop_front());
          req_cycles = 0;
        end
      end else begin
        req_cycles = 0;
      end
    end
  end

  // MMU side: fault injection, hold checks and write scoreboard.
  initial begin
    bit          prev_fault;
    logic [15:0] prev_data;
    prev_fault = 1'b0;
    prev_data  = '0;
    mmu_fault  = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_fault) begin
        chk("wr_hold", reg_write, 1);
        chk("data_hold", reg_data, prev_data);
      end
      if (reg_write === 1'b1 && wr_idx == fault_at && fault_left > 0) begin
        mmu_fault = 1'b1;
        fault_left--;
      end else begin
        mmu_fault = 1'b0;
      end
      prev_fault = mmu_fault;
      prev_data  = reg_data;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (reg_write === 1'b1 && !mmu_fault) begin
        wr_idx++;
        if (exp_w.size() > 0) chk("wr_data", reg_data, exp_w.pop_front());
      end
    end
  end

  task automatic push_model(input logic [3:0] m, input logic [14:0] b, input logic [15:0] sv,
                            output int nr, output int nw);
    nr = 0;
    for (int i = 0; i < 32; i++) begin
      if (m[i/8]) begin
        logic [4:0] ii;
        ii = 5'(i);
        exp_a.push_back(b + 15'(i));
        exp_w.push_back({ii[2:0], 9'd0, ii[4], ii[3], 2'b00});
        exp_w.push_back({ii, 11'd0} | 16'h0007);
        nr++;
      end
    end
    if (nr > 0) exp_w.push_back({sv[15:1], 1'b0});
    nw = (nr > 0) ? 2*nr + 1 : 0;
  endtask

  task automatic do_start(input logic [3:0] m, input logic [14:0] b);
    @(posedge clk); #1;
    bank_mask = m;
    base_addr = b;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = ~b;
    bank_mask = ~m;
  endtask

  task automatic run_load(input logic [3:0] m, input logic [14:0] b, input logic [15:0] sv,
                          input int dly, input int fat, input int flen, input int exp_cyc);
    int nr, nw, cyc;
    bit seen;
    ack_delay  = dly;
    fault_at   = fat;
    fault_left = flen;
    tb_base    = b;
    reg_read   = sv;
    wr_idx = 0; rd_cnt = 0; busy_cnt = 0; done_cnt = 0;
    push_model(m, b, sv, nr, nw);
    do_start(m, b);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    chk("load_cycles", cyc, exp_cyc);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("busy_cycles", busy_cnt, (nr == 0) ? 0 : exp_cyc - 1);
    chk("reads", rd_cnt, nr);
    chk("writes", wr_idx, nw);
    chk("queue_left", exp_w.size() + exp_a.size(), 0);
  endtask

  initial begin
    int nr, nw, cyc;
    bit seen;
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    bank_mask = '0;
    reg_read  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_reg_data", reg_data, 0);
    reset_n = 1'b1;

    run_load(4'hF,    15'h0100, 16'h1235, 0, -1, 0, 99);
    run_load(4'b0100, 15'h0100, 16'hABCD, 0, -1, 0, 27);
    run_load(4'h0,    15'h0100, 16'h0000, 0, -1, 0, 1);
    run_load(4'hF,    15'h0100, 16'h1235, 0, 2, 2, 101);
    run_load(4'hF,    15'h0200, 16'h4321, 3, -1, 0, 195);
    run_load(4'hF,    15'h7FF0, 16'h6008, 0, -1, 0, 99);

    // Reset in the middle of entry 10, then a clean reload.
    ack_delay = 0; fault_at = -1; fault_left = 0;
    tb_base = 15'h0100; reg_read = 16'h1235;
    push_model(4'hF, 15'h0100, 16'h1235, nr, nw);
    do_start(4'hF, 15'h0100);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (mem_req === 1'b1 && mem_addr === 15'h010A) seen = 1'b1;
    end
    chk("reach_entry10", seen, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_reg_write", reg_write, 0);
    chk("midrst_reg_data", reg_data, 0);
    exp_w.delete();
    exp_a.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_load(4'hF, 15'h0100, 16'h1235, 0, -1, 0, 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
